mux_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the 4:1 single-bit mux datapath (inputs a..d, select s[1:0], output y) between four requesters.
- Each requester owns one mux data leg; the block drives the select, issues a one-hot grant and registers the selected bit.
- A timeslice counter bounds how long one requester holds the mux.
- Sits between the top-level pin wrapper and the mux: ui_in supplies req/data, uo_out carries grant/y.

---
 rtl/mux_arb_pkg.sv | 41 ++++
 rtl/rr_pick.sv | 18 +
 rtl/mux_rr_arbiter.sv | 96 +++++++++
 tb/tb_mux_rr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter: state encoding,
// requester geometry and the rotating-priority pick.
package mux_arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic             any;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scan last+1, last+2, last+3, last (mod NUM_REQ); first set request wins.
  function automatic pick_t rr_pick_fn(input logic [NUM_REQ-1:0] req,
                                       input logic [SEL_W-1:0]   last);
    pick_t            p;
    logic [SEL_W-1:0] k;
    p = '{any: 1'b0, idx: '0};
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      k = last + SEL_W'(i);
      if (!p.any && req[k]) begin
        p.any = 1'b1;
        p.idx = k;
      end
    end
    return p;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational 4-way rotating priority encoder; priority starts just after
// the previous winner.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   winner,
  output logic               any
);

  pick_t pick;

  assign pick   = rr_pick_fn(req, last);
  assign winner = pick.idx;
  assign any    = pick.any;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing the 4:1 single-bit mux between four requesters,
// with a timeslice bound on ownership and a lock that defers preemption.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned SLICE = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [3:0] req,
  input  logic [3:0] din,
  input  logic       lock,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       y,
  output logic       y_vld,
  output logic       busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SLICE - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] last;
  logic [SEL_W-1:0] winner;
  logic             any;
  logic             owner_req;
  logic             contender;
  logic             expired;

  rr_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (winner),
    .any    (any)
  );

  // In GRANT last == sel, so the owner is scanned last and any other request wins.
  assign owner_req = req[sel];
  assign contender = any && (winner != sel);
  assign expired   = (cnt == '0) && !lock;
  assign busy      = (state == GRANT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      y     <= 1'b0;
      y_vld <= 1'b0;
      cnt   <= '0;
      last  <= 2'd3;
    end else if (ena) begin
      case (state)
        IDLE: begin
          y_vld <= 1'b0;
          if (any) begin
            state <= GRANT;
            grant <= onehot(winner);
            sel   <= winner;
            last  <= winner;
            cnt   <= RELOAD;
          end
        end
        GRANT: begin
          y     <= din[sel];
          y_vld <= 1'b1;
          if (!owner_req) begin
            if (any) begin
              grant <= onehot(winner);
              sel   <= winner;
              last  <= winner;
              cnt   <= RELOAD;
            end else begin
              state <= IDLE;
              grant <= '0;
            end
          end else if (expired) begin
            cnt <= RELOAD;
            if (contender) begin
              grant <= onehot(winner);
              sel   <= winner;
              last  <= winner;
            end
          end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed scenarios then random traffic,
// checked every cycle against an ownership/held-cycles reference model.
module tb_mux_rr_arbiter;

  localparam int unsigned SLICE = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] req;
  logic [3:0] din;
  logic       lock;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       y;
  logic       y_vld;
  logic       busy;

  mux_rr_arbiter #(.SLICE(SLICE), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .req   (req),
    .din   (din),
    .lock  (lock),
    .grant (grant),
    .sel   (sel),
    .y     (y),
    .y_vld (y_vld),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       y;
    logic       y_vld;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: who owns the mux and how many cycles it has held it.
  int       owner;
  int       m_last;
  int       held;
  logic     m_y;
  logic     m_yv;
  logic [1:0] m_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req_v, $time);
    end
  endtask

  function automatic int rr(input logic [3:0] r, input int lst);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (lst + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner  = -1;
    m_last = 3;
    held   = 0;
    m_y    = 1'b0;
    m_yv   = 1'b0;
    m_sel  = 2'd0;
  endtask

  task automatic take(input int w);
    owner  = w;
    m_last = w;
    m_sel  = 2'(w);
    held   = 1;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [3:0] d,
                            input logic lk, input logic en);
    int w;
    if (!en) return;
    w = rr(r, m_last);
    if (owner < 0) begin
      m_yv = 1'b0;
      if (w >= 0) take(w);
    end else begin
      m_y  = d[owner];
      m_yv = 1'b1;
      if (!r[owner]) begin
        if (w >= 0) take(w);
        else owner = -1;
      end else if (held >= int'(SLICE) && !lk) begin
        if (w != owner) take(w);
        else held = 1;
      end else begin
        held++;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.grant = '0;
    if (owner >= 0) e.grant[owner] = 1'b1;
    e.sel   = m_sel;
    e.busy  = (owner >= 0);
    e.y     = m_y;
    e.y_vld = m_yv;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive at negedge, advance the model at posedge.
  task automatic step(input logic rv, input logic [3:0] r, input logic [3:0] d,
                      input logic lk, input logic en);
    logic falling;
    @(negedge clk);
    falling = rst_n && !rv;
    rst_n = rv;
    req   = r;
    din   = d;
    lock  = lk;
    ena   = en;
    if (!rv) model_reset();
    if (falling) begin
      #1;
      chk("async_rst_grant", 32'(grant), 32'd0);
      chk("async_rst_y", 32'(y), 32'd0);
      chk("async_rst_y_vld", 32'(y_vld), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk);
    if (rv) model_edge(r, d, lk, en);
    push_exp();
  endtask

  // Monitor: one expected record per clock edge, checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("grant", 32'(grant), 32'(e.grant));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("y_vld", 32'(y_vld), 32'(e.y_vld));
        if (e.busy) chk("sel", 32'(sel), 32'(e.sel));
        if (e.y_vld) chk("y", 32'(y), 32'(e.y));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = 4'b0000;
    din   = 4'b0000;
    lock  = 1'b0;
    model_reset();

    // Reset held with all requesting, then release: requester 0 first.
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 4'b0101, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b1);

    // Lone requester keeps the mux without bubbles.
    for (int i = 0; i < 20; i++) step(1'b1, 4'b0100, 4'($urandom_range(0, 15)), 1'b0, 1'b1);

    // Owner 1 drops while requester 3 waits.
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 4'b1010, 1'b0, 1'b1);
    step(1'b1, 4'b1010, 4'b1010, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1000, 4'($urandom_range(0, 15)), 1'b0, 1'b1);

    // Lock holds owner 0 well past expiry, then releases to requester 1.
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) step(1'b1, 4'b0011, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0011, 4'($urandom_range(0, 15)), 1'b0, 1'b1);

    // Asynchronous reset mid-grant with toggling data.
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1110, 4'(i % 2 ? 4'b1111 : 4'b0000), 1'b0, 1'b1);
    step(1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1);
    step(1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b1);

    // Freeze mid-slice, then resume.
    step(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, 4'($urandom_range(0, 15)), 1'b0, 1'b1);

    // Random traffic with sticky requests, occasional lock, stall and reset.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 99) != 0), r, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) != 0));
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
